// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage: defaults,
// the NOP filler word, the FSM state type and the prefetch queue entry.
package fetch_pkg;

    localparam int          FETCH_DEPTH    = 4;
    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Fetch addresses are always word aligned; the low two bits are dropped.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Bus bundles of the fetch stage: the instruction-memory request/response
// channel and the fetch-to-decode valid/ready channel.
interface fetch_imem_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

interface fetch_id_if;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;

    modport master (
        output id_valid,
        input  id_ready,
        output id_instr,
        output id_pc,
        output id_pc_plus4
    );

    modport slave (
        input  id_valid,
        output id_ready,
        input  id_instr,
        input  id_pc,
        input  id_pc_plus4
    );
endinterface

// File: rtl/fetch_fifo.sv
// Prefetch queue of {pc, instr} entries with a single-cycle flush.
// The head is read combinationally so a pushed entry is visible next cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full, empty;
    logic          push_en, pop_en;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_en = push && !full && !flush;
    assign pop_en  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(push_en) - CW'(pop_en);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: credit-limited prefetch into a small queue, with
// redirect handling that drains in-flight responses in the FLUSH state.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = FETCH_DEPTH,
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    fetch_imem_if.master      imem,
    fetch_id_if.master        id,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outst_q, outst_d;

    logic [CW-1:0] fifo_count;
    fetch_entry_t  fifo_head;
    fetch_entry_t  push_entry;
    logic [CW:0]   credit_used;
    logic [31:0]   redirect_target;
    logic [31:0]   head_pc;
    logic          q_valid;
    logic          fetch_req;
    logic          grant;
    logic          resp;
    logic          push;
    logic          pop;

    assign redirect_target = align_pc(redirect_pc);
    assign credit_used     = {1'b0, fifo_count} + {1'b0, outst_q};
    assign q_valid         = (fifo_count != '0);

    // Every request already granted reserves a queue slot, so a response
    // always finds room and the queue can never overflow.
    assign fetch_req = (state_q == ST_RUN) && !rst && (credit_used < (CW+1)'(DEPTH));
    assign grant     = fetch_req && imem.imem_gnt;

    // A response with nothing outstanding belongs to a request issued
    // before the last reset and is ignored entirely.
    assign resp = imem.imem_rvalid && (outst_q != '0);
    assign push = resp && (state_q == ST_RUN) && !redirect_valid;
    assign pop  = q_valid && id.id_ready;

    assign push_entry = '{pc: resp_pc_q, instr: imem.imem_rdata};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        outst_d    = outst_q + CW'(grant) - CW'(resp);

        if (redirect_valid) begin
            fetch_pc_d = redirect_target;
            resp_pc_d  = redirect_target;
        end else begin
            if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
            if (push)  resp_pc_d  = resp_pc_q + 32'd4;
        end

        // A grant in the redirect cycle is still in flight and must drain.
        case (state_q)
            ST_RUN: begin
                if (redirect_valid && (outst_d != '0)) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (outst_d == '0) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign imem.imem_req  = fetch_req;
    assign imem.imem_addr = fetch_pc_q;

    assign head_pc        = q_valid ? fifo_head.pc : 32'h0;
    assign id.id_valid    = q_valid;
    assign id.id_instr    = q_valid ? fifo_head.instr : NOP_INSTR;
    assign id.id_pc       = head_pc;
    assign id.id_pc_plus4 = head_pc + 32'd4;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle vector tables against a simple
// in-order memory model, plus a hand-written asynchronous reset sequence.
module tb_fetch_stage;
    import fetch_pkg::*;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    fetch_imem_if imem_bus();
    fetch_id_if   id_bus();

    fetch_stage #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem           (imem_bus),
        .id             (id_bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        gnt;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        stale;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    vec_t  vecs[$];
    pend_t mq[$];
    int    n_cmp  = 0;
    int    n_fail = 0;
    int    cyc    = 0;
    int    lat    = 1;
    bit    const_mode = 1'b0;
    string phase  = "init";

    function automatic logic [31:0] mem_data(input logic [31:0] addr);
        return const_mode ? 32'h0050_0093 : (addr ^ 32'h5A00_0013);
    endfunction

    task automatic chk(input string name, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s row %0d: got %h expected %h", phase, name, row, act, exp);
        end
    endtask

    task automatic add(input logic gnt, input logic rdy, input logic redir,
                       input logic [31:0] rpc, input logic stale,
                       input logic e_req, input logic [31:0] e_addr,
                       input logic e_valid, input logic [31:0] e_pc);
        vec_t v;
        v.gnt = gnt; v.rdy = rdy; v.redir = redir; v.rpc = rpc; v.stale = stale;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
        vecs.push_back(v);
    endtask

    task automatic do_cycle(input vec_t r, input int idx);
        logic        resp_now;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        resp_now = 1'b0;
        imem_bus.imem_gnt = r.gnt;
        id_bus.id_ready   = r.rdy;
        redirect_valid    = r.redir;
        redirect_pc       = r.rpc;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            resp_now = 1'b1;
            imem_bus.imem_rvalid = 1'b1;
            imem_bus.imem_rdata  = mem_data(mq[0].addr);
        end else if (r.stale) begin
            imem_bus.imem_rvalid = 1'b1;
            imem_bus.imem_rdata  = 32'hDEAD_BEEF;
        end else begin
            imem_bus.imem_rvalid = 1'b0;
            imem_bus.imem_rdata  = $urandom;
        end
        @(negedge clk);
        exp_pc    = r.e_valid ? r.e_pc : 32'h0;
        exp_instr = r.e_valid ? mem_data(r.e_pc) : NOP_INSTR;
        chk("imem_req", idx, {31'b0, imem_bus.imem_req}, {31'b0, r.e_req});
        if (r.e_req) chk("imem_addr", idx, imem_bus.imem_addr, r.e_addr);
        chk("id_valid", idx, {31'b0, id_bus.id_valid}, {31'b0, r.e_valid});
        chk("id_pc", idx, id_bus.id_pc, exp_pc);
        chk("id_pc_plus4", idx, id_bus.id_pc_plus4, exp_pc + 32'd4);
        chk("id_instr", idx, id_bus.id_instr, exp_instr);
        $display("[%s] row %0d req=%0b addr=%h valid=%0b pc=%h instr=%h",
                 phase, idx, imem_bus.imem_req, imem_bus.imem_addr,
                 id_bus.id_valid, id_bus.id_pc, id_bus.id_instr);
        if (resp_now) void'(mq.pop_front());
        if (imem_bus.imem_req && imem_bus.imem_gnt)
            mq.push_back('{imem_bus.imem_addr, cyc + lat});
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_table();
        for (int i = 0; i < vecs.size(); i++) do_cycle(vecs[i], i);
        vecs.delete();
    endtask

    task automatic idle_inputs();
        imem_bus.imem_gnt    = 1'b0;
        imem_bus.imem_rvalid = 1'b0;
        imem_bus.imem_rdata  = 32'h0;
        id_bus.id_ready      = 1'b0;
        redirect_valid       = 1'b0;
        redirect_pc          = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        mq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();

        // Basic streaming with a constant instruction word, 1-cycle latency.
        phase = "stream"; const_mode = 1'b1; lat = 1;
        do_reset();
        add(1,1,0,0,0, 1,32'h00,0,0);
        add(1,1,0,0,0, 1,32'h04,0,0);
        add(1,1,0,0,0, 1,32'h08,1,32'h00);
        add(1,1,0,0,0, 1,32'h0C,1,32'h04);
        add(1,1,0,0,0, 1,32'h10,1,32'h08);
        run_table();

        // Decode stalled: exactly DEPTH grants, then requests resume on pops.
        phase = "backpressure"; const_mode = 1'b0; lat = 1;
        do_reset();
        add(1,0,0,0,0, 1,32'h00,0,0);
        add(1,0,0,0,0, 1,32'h04,0,0);
        add(1,0,0,0,0, 1,32'h08,1,32'h00);
        add(1,0,0,0,0, 1,32'h0C,1,32'h00);
        add(1,0,0,0,0, 0,32'h00,1,32'h00);
        add(1,0,0,0,0, 0,32'h00,1,32'h00);
        add(1,0,0,0,0, 0,32'h00,1,32'h00);
        add(1,1,0,0,0, 0,32'h00,1,32'h00);
        add(1,0,0,0,0, 1,32'h10,1,32'h04);
        add(1,1,0,0,0, 0,32'h00,1,32'h04);
        add(1,1,0,0,0, 1,32'h14,1,32'h08);
        add(1,1,0,0,0, 1,32'h18,1,32'h0C);
        add(1,1,0,0,0, 1,32'h1C,1,32'h10);
        add(1,1,0,0,0, 1,32'h20,1,32'h14);
        add(1,1,0,0,0, 1,32'h24,1,32'h18);
        run_table();

        // Redirect with two outstanding (plus a grant in the same cycle).
        phase = "flush"; lat = 2;
        do_reset();
        add(1,1,0,0,0,            1,32'h000,0,0);
        add(1,1,0,0,0,            1,32'h004,0,0);
        add(1,1,1,32'h0000_0103,0, 1,32'h008,0,0);
        add(1,1,0,0,0,            0,32'h000,0,0);
        add(1,1,0,0,0,            0,32'h000,0,0);
        add(1,1,0,0,0,            1,32'h100,0,0);
        add(1,1,0,0,0,            1,32'h104,0,0);
        add(1,1,0,0,0,            1,32'h108,0,0);
        add(1,1,0,0,0,            1,32'h10C,1,32'h100);
        add(1,1,0,0,0,            1,32'h110,1,32'h104);
        run_table();

        // Second redirect while still flushing: the later target wins.
        phase = "reflush"; lat = 3;
        do_reset();
        add(1,1,0,0,0,            1,32'h000,0,0);
        add(1,1,0,0,0,            1,32'h004,0,0);
        add(0,1,1,32'h0000_0200,0, 1,32'h008,0,0);
        add(1,1,1,32'h0000_0300,0, 0,32'h000,0,0);
        add(1,1,0,0,0,            0,32'h000,0,0);
        add(1,1,0,0,0,            1,32'h300,0,0);
        add(1,1,0,0,0,            1,32'h304,0,0);
        add(1,1,0,0,0,            1,32'h308,0,0);
        add(1,1,0,0,0,            1,32'h30C,0,0);
        add(1,1,0,0,0,            0,32'h000,1,32'h300);
        add(1,1,0,0,0,            1,32'h310,1,32'h304);
        add(1,1,0,0,0,            1,32'h314,1,32'h308);
        run_table();

        // Address wrap at the top of the 32-bit space.
        phase = "wrap"; lat = 1;
        do_reset();
        add(0,1,1,32'hFFFF_FFFA,0, 1,32'h0000_0000,0,0);
        add(1,1,0,0,0,             1,32'hFFFF_FFF8,0,0);
        add(1,1,0,0,0,             1,32'hFFFF_FFFC,0,0);
        add(1,1,0,0,0,             1,32'h0000_0000,1,32'hFFFF_FFF8);
        add(1,1,0,0,0,             1,32'h0000_0004,1,32'hFFFF_FFFC);
        add(1,1,0,0,0,             1,32'h0000_0008,1,32'h0000_0000);
        run_table();

        // Pop in the redirect cycle; nothing left in flight so no FLUSH.
        phase = "redir_pop"; lat = 1;
        do_reset();
        add(1,0,0,0,0,            1,32'h00,0,0);
        add(1,0,0,0,0,            1,32'h04,0,0);
        add(1,0,0,0,0,            1,32'h08,1,32'h00);
        add(0,1,1,32'h0000_0040,0, 1,32'h0C,1,32'h00);
        add(1,1,0,0,0,            1,32'h40,0,0);
        add(1,1,0,0,0,            1,32'h44,0,0);
        add(1,1,0,0,0,            1,32'h48,1,32'h40);
        run_table();

        // Asynchronous reset with two outstanding and entries queued.
        phase = "reset_mid"; lat = 2;
        do_reset();
        add(1,0,0,0,0, 1,32'h00,0,0);
        add(1,0,0,0,0, 1,32'h04,0,0);
        add(1,0,0,0,0, 1,32'h08,0,0);
        add(1,0,0,0,0, 1,32'h0C,1,32'h00);
        run_table();
        rst = 1'b1;
        imem_bus.imem_rvalid = 1'b0;
        #1;
        chk("rst_imem_req", 0, {31'b0, imem_bus.imem_req}, 32'h0);
        chk("rst_imem_addr", 0, imem_bus.imem_addr, 32'h0000_0000);
        chk("rst_id_valid", 0, {31'b0, id_bus.id_valid}, 32'h0);
        chk("rst_id_instr", 0, id_bus.id_instr, NOP_INSTR);
        chk("rst_id_pc", 0, id_bus.id_pc, 32'h0);
        chk("rst_id_pc_plus4", 0, id_bus.id_pc_plus4, 32'h4);
        $display("[%s] async reset asserted req=%0b addr=%h valid=%0b",
                 phase, imem_bus.imem_req, imem_bus.imem_addr, id_bus.id_valid);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_imem_req", 1, {31'b0, imem_bus.imem_req}, 32'h0);
        mq.delete();
        rst = 1'b0;
        cyc = 0;
        lat = 1;
        phase = "post_reset";
        add(0,1,0,0,1, 1,32'h00,0,0);
        add(1,1,0,0,0, 1,32'h00,0,0);
        add(1,1,0,0,0, 1,32'h04,0,0);
        add(1,1,0,0,0, 1,32'h08,1,32'h00);
        run_table();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
